fifo_rd_stream: RTL and testbench

Read-side consumer for the dual-clock FIFO. It lives in the `rd_clk` domain and drives the FIFO read port (`pop`/`empty`/`data_out`). It fetches a software-specified burst of words and presents them on a valid/ready stream with a last-beat marker. The FIFO RAM has a one-cycle registered read latency; this block hides it behind a 2-entry output buffer and sustains one word per cycle when the FIFO is non-empty and the sink is ready.

---
 rtl/fifo_rd_stream_if.sv | 17 +
 rtl/fifo_rd_stream.sv | 120 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready output stream of the FIFO read-side consumer.
//   m_valid : word on m_data is valid
//   m_ready : sink accepts the word this cycle
//   m_data  : output word (W_DATA bits)
//   m_last  : final word of the current burst
// master = block driving the stream, slave = sink.
interface fifo_rd_stream_if #(
  parameter int W_DATA = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [W_DATA-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side burst consumer for the dual-clock FIFO (rd_clk domain).
// Pops a software-specified number of words and presents them on a valid/ready
// stream with a last-beat marker. The FIFO read data arrives one cycle after
// the pop, so a 2-entry buffer absorbs that latency and keeps 1 word/cycle.
//   rd_clk, rd_rst      : clock, async active-low reset
//   start, burst_len    : burst request (sampled in IDLE only)
//   busy, done          : burst in progress / one-cycle completion pulse
//   fifo_empty, fifo_pop, fifo_data : FIFO read port
//   m                   : output stream (master modport)
module fifo_rd_stream #(
  parameter int W_DATA = 8,
  parameter int W_LEN  = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              start,
  input  logic [W_LEN-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  input  logic [W_DATA-1:0] fifo_data,
  fifo_rd_stream_if.master  m
);

  localparam logic [W_LEN-1:0] ONE = W_LEN'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [W_LEN-1:0]  len, issued, sent;
  logic [1:0]        occ;
  logic              inflight;
  logic [W_DATA-1:0] buf0, buf1;   // buf0 is the head
  logic              deq;
  logic [2:0]        pend;
  logic              start_run, start_zero;

  assign deq        = m.m_valid & m.m_ready;
  // Slots that will be committed after this cycle, not counting a new pop.
  assign pend       = {1'b0, occ} + {2'b0, inflight} - {2'b0, deq};
  assign start_run  = (state == IDLE) & start & (burst_len != '0);
  assign start_zero = (state == IDLE) & start & (burst_len == '0);

  // ---- state register ----
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // ---- next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_run) state_nxt = RUN;
             else if (start_zero) state_nxt = DONE;
      RUN:   if (fifo_pop && (issued == len - ONE)) state_nxt = DRAIN;
      DRAIN: if (deq && (sent == len - ONE)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    busy     = (state == RUN) | (state == DRAIN);
    done     = (state == DONE);
    fifo_pop = (state == RUN) & ~fifo_empty & (issued < len) & (pend < 3'd2);
  end

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = buf0;
  assign m.m_last  = m.m_valid & (sent == len - ONE);

  // ---- counters and output buffer ----
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      len      <= '0;
      issued   <= '0;
      sent     <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_pop;
      if (start_run) begin
        len    <= burst_len;
        issued <= '0;
        sent   <= '0;
      end else begin
        if (fifo_pop) issued <= issued + ONE;
        if (deq)      sent   <= sent + ONE;
      end
      // Word returning from the FIFO lands at the tail; a dequeue shifts
      // buf1 into the head. Both together keep occ and write behind the
      // surviving entry.
      case ({inflight, deq})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_data;
          else             buf1 <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) buf0 <= fifo_data;
          else begin
            buf0 <= buf1;
            buf1 <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       start;
  logic [7:0] burst_len;
  logic       busy, done;
  logic       fifo_empty = 1'b1;
  logic       fifo_pop;
  logic [7:0] fifo_data = 8'h00;

  fifo_rd_stream_if #(.W_DATA(8)) s ();

  fifo_rd_stream #(.W_DATA(8), .W_LEN(8)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_data(fifo_data), .m(s)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: registered empty flag, data valid one cycle after a pop.
  logic [7:0] mem [0:1023];
  int rd_ptr = 0, wr_ptr = 0, npops = 0, pop_err = 0;
  int nxt;
  always @(posedge rd_clk) begin
    nxt = rd_ptr;
    if (fifo_pop) begin
      if (rd_ptr == wr_ptr) pop_err <= pop_err + 1;
      else begin
        fifo_data <= mem[rd_ptr];
        nxt = rd_ptr + 1;
      end
      npops <= npops + 1;
    end
    rd_ptr     <= nxt;
    fifo_empty <= (nxt == wr_ptr);
  end

  int errors = 0, checks = 0;

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic test_reset();
    rd_rst = 1'b0; start = 1'b0; burst_len = 8'd0; s.m_ready = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=0", fifo_pop); end
    checks++; if (s.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", s.m_valid); end
    checks++; if (s.m_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", s.m_last); end
    checks++; if (s.m_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", s.m_data); end
    rd_rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int p0;
    for (int k = 0; k < 4; k++) push(8'h11 + 8'(k));
    tick();
    p0 = npops; s.m_ready = 1'b1; burst_len = 8'd4; start = 1'b1;
    tick(); start = 1'b0;
    checks++; if (busy !== 1'b1 || fifo_pop !== 1'b1 || s.m_valid !== 1'b0) begin
      errors++; $display("FAIL basic_c1 busy=%b pop=%b valid=%b exp 1 1 0", busy, fifo_pop, s.m_valid); end
    tick();
    checks++; if (s.m_valid !== 1'b0) begin errors++; $display("FAIL basic_c1_valid got=%b exp=0", s.m_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (s.m_valid !== 1'b1 || s.m_data !== 8'h11 + 8'(k) || s.m_last !== (k == 3)) begin
        errors++; $display("FAIL basic_beat%0d valid=%b data=%h last=%b exp 1 %h %b",
                           k, s.m_valid, s.m_data, s.m_last, 8'h11 + 8'(k), k == 3);
      end
    end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || s.m_valid !== 1'b0) begin
      errors++; $display("FAIL basic_done done=%b busy=%b valid=%b exp 1 0 0", done, busy, s.m_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (npops - p0 != 4) begin errors++; $display("FAIL basic_pops got=%0d exp=4", npops - p0); end
  endtask

  task automatic test_backpressure();
    int p0, hs, dn;
    logic stalled;
    logic [7:0] pdata;
    logic plast;
    for (int k = 0; k < 8; k++) push(8'h20 + 8'(k));
    tick();
    p0 = npops; hs = 0; dn = 0; stalled = 1'b0; pdata = 8'h00; plast = 1'b0;
    burst_len = 8'd8; start = 1'b1; s.m_ready = 1'b0;
    tick(); start = 1'b0;
    for (int cyc = 0; cyc < 100 && dn == 0; cyc++) begin
      s.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (done === 1'b1) dn++;
      checks++; if (npops - p0 - hs > 2) begin
        errors++; $display("FAIL bp_occupancy cyc=%0d ahead=%0d exp<=2", cyc, npops - p0 - hs); end
      if (stalled) begin
        checks++; if (s.m_valid !== 1'b1 || s.m_data !== pdata || s.m_last !== plast) begin
          errors++; $display("FAIL bp_stable cyc=%0d data=%h last=%b exp %h %b", cyc, s.m_data, s.m_last, pdata, plast); end
      end
      if (s.m_valid === 1'b1 && s.m_ready === 1'b1) begin
        checks++; if (s.m_data !== 8'h20 + 8'(hs) || s.m_last !== (hs == 7)) begin
          errors++; $display("FAIL bp_beat%0d data=%h last=%b exp %h %b", hs, s.m_data, s.m_last, 8'h20 + 8'(hs), hs == 7); end
        hs++;
      end
      stalled = s.m_valid & ~s.m_ready;
      pdata = s.m_data; plast = s.m_last;
      if (dn == 0) tick();
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL bp_done_timeout got=%0d exp=1", dn); end
    checks++; if (hs != 8 || npops - p0 != 8) begin
      errors++; $display("FAIL bp_counts beats=%0d pops=%0d exp 8 8", hs, npops - p0); end
    s.m_ready = 1'b1;
    tick();
  endtask

  task automatic test_empty_mid();
    int p0, n, dn;
    push(8'h30);
    tick();
    p0 = npops; n = 0; dn = 0; s.m_ready = 1'b1; burst_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 10) begin
        checks++; if (npops - p0 != 1) begin errors++; $display("FAIL empty_gap_pops got=%0d exp=1", npops - p0); end
        push(8'h31); push(8'h32);
      end
      if (fifo_empty === 1'b1 && fifo_pop === 1'b1) begin
        checks++; errors++; $display("FAIL empty_pop cyc=%0d pop=1 exp=0", cyc);
      end
      if (done === 1'b1) dn++;
      if (s.m_valid === 1'b1) begin
        checks++; if (s.m_data !== 8'h30 + 8'(n) || s.m_last !== (n == 2)) begin
          errors++; $display("FAIL empty_beat%0d data=%h last=%b exp %h %b", n, s.m_data, s.m_last, 8'h30 + 8'(n), n == 2); end
        n++;
      end
      tick();
    end
    checks++; if (n != 3 || dn != 1 || npops - p0 != 3) begin
      errors++; $display("FAIL empty_counts beats=%0d dones=%0d pops=%0d exp 3 1 3", n, dn, npops - p0); end
  endtask

  task automatic test_zero_ignored();
    int p0, n, dn;
    p0 = npops;
    burst_len = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0 || s.m_valid !== 1'b0) begin
      errors++; $display("FAIL zero_done done=%b busy=%b pop=%b valid=%b exp 1 0 0 0", done, busy, fifo_pop, s.m_valid); end
    tick();
    checks++; if (done !== 1'b0 || s.m_valid !== 1'b0 || npops != p0) begin
      errors++; $display("FAIL zero_after done=%b valid=%b pops=%0d exp 0 0 0", done, s.m_valid, npops - p0); end
    for (int k = 0; k < 4; k++) push(8'h50 + 8'(k));
    tick();
    p0 = npops; n = 0; dn = 0; s.m_ready = 1'b0; burst_len = 8'd2; start = 1'b1;
    tick(); burst_len = 8'd3;   // start still high: arrives while busy
    tick(); start = 1'b0; s.m_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done === 1'b1) dn++;
      if (s.m_valid === 1'b1) begin
        checks++; if (s.m_data !== 8'h50 + 8'(n) || s.m_last !== (n == 1)) begin
          errors++; $display("FAIL ign_beat%0d data=%h last=%b exp %h %b", n, s.m_data, s.m_last, 8'h50 + 8'(n), n == 1); end
        n++;
      end
      tick();
    end
    checks++; if (n != 2 || dn != 1 || npops - p0 != 2) begin
      errors++; $display("FAIL ign_counts beats=%0d dones=%0d pops=%0d exp 2 1 2", n, dn, npops - p0); end
    wr_ptr = rd_ptr;   // drop leftover words
    tick();
  endtask

  task automatic test_reset_mid();
    int p0, n, dn;
    for (int k = 0; k < 8; k++) push(8'h40 + 8'(k));
    tick();
    p0 = npops; s.m_ready = 1'b0; burst_len = 8'd8; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    checks++; if (s.m_valid !== 1'b1 || npops - p0 != 2) begin
      errors++; $display("FAIL rstmid_pre valid=%b pops=%0d exp 1 2", s.m_valid, npops - p0); end
    #3 rd_rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || fifo_pop !== 1'b0 || s.m_valid !== 1'b0 ||
                  s.m_last !== 1'b0 || s.m_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_outputs busy=%b done=%b pop=%b valid=%b last=%b data=%h exp all 0",
                         busy, done, fifo_pop, s.m_valid, s.m_last, s.m_data); end
    #2 rd_rst = 1'b1;
    tick();
    n = 0; dn = 0; s.m_ready = 1'b1; burst_len = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (done === 1'b1) dn++;
      if (s.m_valid === 1'b1) begin
        checks++; if (s.m_data !== 8'h42 + 8'(n) || s.m_last !== (n == 1)) begin
          errors++; $display("FAIL rstmid_beat%0d data=%h last=%b exp %h %b", n, s.m_data, s.m_last, 8'h42 + 8'(n), n == 1); end
        n++;
      end
      tick();
    end
    checks++; if (n != 2 || dn != 1) begin errors++; $display("FAIL rstmid_counts beats=%0d dones=%0d exp 2 1", n, dn); end
    wr_ptr = rd_ptr;
    tick();
  endtask

  task automatic test_max_len();
    int p0, n, dn;
    for (int k = 1; k <= 255; k++) push(8'(k));
    tick();
    p0 = npops; n = 0; dn = 0; s.m_ready = 1'b1; burst_len = 8'd255; start = 1'b1;
    tick(); start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done === 1'b1) dn++;
      if (s.m_valid === 1'b1) begin
        checks++; if (s.m_data !== 8'(n + 1) || s.m_last !== (n == 254)) begin
          errors++; $display("FAIL max_beat%0d data=%h last=%b exp %h %b", n, s.m_data, s.m_last, 8'(n + 1), n == 254); end
        n++;
      end
      tick();
    end
    checks++; if (n != 255 || dn != 1 || npops - p0 != 255) begin
      errors++; $display("FAIL max_counts beats=%0d dones=%0d pops=%0d exp 255 1 255", n, dn, npops - p0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_mid();
    test_zero_ignored();
    test_reset_mid();
    test_max_len();
    checks++; if (pop_err != 0) begin errors++; $display("FAIL pop_on_empty got=%0d exp=0", pop_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
